// File: rtl/axis_weight_rotator_sched.sv
// Read-side scheduler for the rotator's two-bank weight BRAM.
// Tracks bank fill state and replays each filled bank as config beats followed by weight beats.
module axis_weight_rotator_sched #(
    parameter int BITS_R_ADDR    = 10,
    parameter int BITS_KH        = 4,
    parameter int BITS_IM_CIN    = 10,
    parameter int BITS_IM_COLS   = 10,
    parameter int BITS_IM_BLOCKS = 8,
    parameter int BITS_CFG       = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    output logic                      w_ready,
    output logic                      w_bank,
    input  logic                      w_done,
    input  logic [BITS_KH-1:0]        w_kh_1,
    input  logic [BITS_IM_CIN-1:0]    w_cin_1,
    input  logic [BITS_IM_COLS-1:0]   w_cols_1,
    input  logic [BITS_IM_BLOCKS-1:0] w_blocks_1,
    input  logic [BITS_CFG-1:0]       w_cfg_1,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic                      r_bank,
    output logic [BITS_R_ADDR-1:0]    r_addr,
    output logic                      r_is_config,
    output logic                      r_cin_last,
    output logic                      r_top_blk,
    output logic                      r_bot_blk,
    output logic                      r_last,
    output logic                      err_ovf
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIG  = 2'd1,
        S_WEIGHTS = 2'd2
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_full;
    logic                      r_wb;
    logic                      r_rb;
    logic [BITS_KH-1:0]        r_kh;
    logic [BITS_IM_CIN-1:0]    r_cin;
    logic [BITS_IM_COLS-1:0]   r_col;
    logic [BITS_IM_BLOCKS-1:0] r_blk;

    logic [BITS_KH-1:0]        r_cfg_kh_1     [2];
    logic [BITS_IM_CIN-1:0]    r_cfg_cin_1    [2];
    logic [BITS_IM_COLS-1:0]   r_cfg_cols_1   [2];
    logic [BITS_IM_BLOCKS-1:0] r_cfg_blocks_1 [2];
    logic [BITS_CFG-1:0]       r_cfg_cfg_1    [2];

    logic                      w_accept;
    logic                      w_hs;
    logic                      w_release;
    logic [1:0]                w_full_nxt;

    logic [BITS_KH-1:0]        w_cur_kh_1;
    logic [BITS_IM_CIN-1:0]    w_cur_cin_1;
    logic [BITS_IM_COLS-1:0]   w_cur_cols_1;
    logic [BITS_IM_BLOCKS-1:0] w_cur_blocks_1;
    logic [BITS_R_ADDR-1:0]    w_cfg_end;
    logic [BITS_R_ADDR-1:0]    w_wgt_base;

    state_t                    w_state_nxt;
    logic                      w_valid_nxt;
    logic                      w_bank_nxt;
    logic [BITS_R_ADDR-1:0]    w_addr_nxt;
    logic [BITS_KH-1:0]        w_kh_nxt;
    logic [BITS_IM_CIN-1:0]    w_cin_nxt;
    logic [BITS_IM_COLS-1:0]   w_col_nxt;
    logic [BITS_IM_BLOCKS-1:0] w_blk_nxt;
    logic                      w_is_config_nxt;
    logic                      w_cin_last_nxt;
    logic                      w_top_nxt;
    logic                      w_bot_nxt;
    logic                      w_last_nxt;

    assign w_ready  = ~r_full[r_wb];
    assign w_bank   = r_wb;
    assign w_accept = w_done & w_ready;
    assign w_hs     = r_valid & r_ready;

    // A bank being replayed is full, so a release and an accept never target the same bank.
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[r_rb] = 1'b0;
        if (w_accept)  w_full_nxt[r_wb] = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_full  <= 2'b00;
            r_wb    <= 1'b0;
            r_rb    <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept)           r_wb    <= ~r_wb;
            if (w_release)          r_rb    <= ~r_rb;
            if (w_done && !w_ready) err_ovf <= 1'b1;
        end
    end

    // NOTE: no reset on the field store; a bank's fields are only read while that bank is full.
    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_cfg_kh_1[r_wb]     <= w_kh_1;
            r_cfg_cin_1[r_wb]    <= w_cin_1;
            r_cfg_cols_1[r_wb]   <= w_cols_1;
            r_cfg_blocks_1[r_wb] <= w_blocks_1;
            r_cfg_cfg_1[r_wb]    <= w_cfg_1;
        end
    end

    assign w_cur_kh_1     = r_cfg_kh_1[r_rb];
    assign w_cur_cin_1    = r_cfg_cin_1[r_rb];
    assign w_cur_cols_1   = r_cfg_cols_1[r_rb];
    assign w_cur_blocks_1 = r_cfg_blocks_1[r_rb];
    assign w_cfg_end      = BITS_R_ADDR'(r_cfg_cfg_1[r_rb]);
    assign w_wgt_base     = w_cfg_end + BITS_R_ADDR'(1);

    // Weight addresses are contiguous (cin outer, kh inner), so the address simply
    // increments and only rewinds at a column or block boundary.
    always_comb begin
        // NOTE: every next-value signal is defaulted to hold first, so no latch can be inferred.
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_bank_nxt  = r_bank;
        w_addr_nxt  = r_addr;
        w_kh_nxt    = r_kh;
        w_cin_nxt   = r_cin;
        w_col_nxt   = r_col;
        w_blk_nxt   = r_blk;
        w_release   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_full[r_rb]) begin
                    w_state_nxt = S_CONFIG;
                    w_valid_nxt = 1'b1;
                    w_bank_nxt  = r_rb;
                    w_addr_nxt  = '0;
                    w_kh_nxt    = '0;
                    w_cin_nxt   = '0;
                    w_col_nxt   = '0;
                    w_blk_nxt   = '0;
                end
            end
            S_CONFIG: begin
                if (w_hs) begin
                    w_addr_nxt = r_addr + BITS_R_ADDR'(1);
                    if (r_addr == w_cfg_end) begin
                        w_state_nxt = S_WEIGHTS;
                        w_kh_nxt    = '0;
                        w_cin_nxt   = '0;
                    end
                end
            end
            S_WEIGHTS: begin
                if (w_hs) begin
                    if (r_kh != w_cur_kh_1) begin
                        w_kh_nxt   = r_kh + BITS_KH'(1);
                        w_addr_nxt = r_addr + BITS_R_ADDR'(1);
                    end else if (r_cin != w_cur_cin_1) begin
                        w_kh_nxt   = '0;
                        w_cin_nxt  = r_cin + BITS_IM_CIN'(1);
                        w_addr_nxt = r_addr + BITS_R_ADDR'(1);
                    end else if (r_col != w_cur_cols_1) begin
                        w_kh_nxt   = '0;
                        w_cin_nxt  = '0;
                        w_col_nxt  = r_col + BITS_IM_COLS'(1);
                        w_addr_nxt = w_wgt_base;
                    end else if (r_blk != w_cur_blocks_1) begin
                        w_state_nxt = S_CONFIG;
                        w_kh_nxt    = '0;
                        w_cin_nxt   = '0;
                        w_col_nxt   = '0;
                        w_blk_nxt   = r_blk + BITS_IM_BLOCKS'(1);
                        w_addr_nxt  = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
                        w_release   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        // Tags are derived from the beat about to be presented; during a stall nothing
        // advances, so they recompute to the same values.
        w_is_config_nxt = (w_state_nxt == S_CONFIG);
        w_cin_last_nxt  = (w_state_nxt == S_WEIGHTS) && (w_cin_nxt == w_cur_cin_1);
        w_top_nxt       = w_valid_nxt && (w_blk_nxt == '0);
        w_bot_nxt       = w_valid_nxt && (w_blk_nxt == w_cur_blocks_1);
        w_last_nxt      = (w_state_nxt == S_WEIGHTS) &&
                          (w_blk_nxt == w_cur_blocks_1) && (w_col_nxt == w_cur_cols_1) &&
                          (w_cin_nxt == w_cur_cin_1) && (w_kh_nxt == w_cur_kh_1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_bank      <= 1'b0;
            r_addr      <= '0;
            r_kh        <= '0;
            r_cin       <= '0;
            r_col       <= '0;
            r_blk       <= '0;
            r_is_config <= 1'b0;
            r_cin_last  <= 1'b0;
            r_top_blk   <= 1'b0;
            r_bot_blk   <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_bank      <= w_bank_nxt;
            r_addr      <= w_addr_nxt;
            r_kh        <= w_kh_nxt;
            r_cin       <= w_cin_nxt;
            r_col       <= w_col_nxt;
            r_blk       <= w_blk_nxt;
            r_is_config <= w_is_config_nxt;
            r_cin_last  <= w_cin_last_nxt;
            r_top_blk   <= w_top_nxt;
            r_bot_blk   <= w_bot_nxt;
            r_last      <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_axis_weight_rotator_sched.sv
// Self-checking bench: a loop-based beat model feeds a scoreboard that one negedge
// monitor compares against the scheduler outputs, plus directed literal expectations.
`timescale 1ns/1ps
module tb_axis_weight_rotator_sched;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       w_ready, w_bank, w_done;
    logic [3:0] w_kh_1;
    logic [9:0] w_cin_1, w_cols_1;
    logic [7:0] w_blocks_1;
    logic [3:0] w_cfg_1;
    logic       r_valid, r_ready, r_bank;
    logic [9:0] r_addr;
    logic       r_is_config, r_cin_last, r_top_blk, r_bot_blk, r_last, err_ovf;

    typedef struct packed {
        logic       bank;
        logic       is_cfg;
        logic       cin_last;
        logic       top;
        logic       bot;
        logic       last;
        logic [9:0] addr;
    } beat_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_arr [1024];
    int    wr_ptr = 0;
    int    rd_ptr = 0;
    int    fill_cnt [2] = '{0, 0};
    int    rel_cnt  [2] = '{0, 0};
    bit    m_wb  = 1'b0;
    bit    m_err = 1'b0;
    beat_t gen_q [$];

    int          hs_cnt = 0;
    int          neg_cyc = 0;
    int          last_hs_cyc = 0;
    int          m_gap = 0;
    bit          have_rel = 1'b0;
    bit          rise_bank = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_valid = 1'b0;
    logic [16:0] prev_vec = '0;

    int lit_b_addr [20] = '{0,1,2,3,4,5,6,7,8,9,10,2,3,4,5,6,7,8,9,10};
    int lit_k_addr [6]  = '{0,1,0,1,0,1};
    int lit_k_cfg  [6]  = '{1,0,1,0,1,0};
    int lit_k_top  [6]  = '{1,1,0,0,0,0};
    int lit_k_bot  [6]  = '{0,0,0,0,1,1};

    axis_weight_rotator_sched dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .w_ready     (w_ready),
        .w_bank      (w_bank),
        .w_done      (w_done),
        .w_kh_1      (w_kh_1),
        .w_cin_1     (w_cin_1),
        .w_cols_1    (w_cols_1),
        .w_blocks_1  (w_blocks_1),
        .w_cfg_1     (w_cfg_1),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_bank      (r_bank),
        .r_addr      (r_addr),
        .r_is_config (r_is_config),
        .r_cin_last  (r_cin_last),
        .r_top_blk   (r_top_blk),
        .r_bot_blk   (r_bot_blk),
        .r_last      (r_last),
        .err_ovf     (err_ovf)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic bit m_full(input bit b);
        return fill_cnt[b] != rel_cnt[b];
    endfunction

    // Beat list of one bank, straight from the nesting: blocks, then config beats,
    // then cols x cin x kh weight beats at cfg_1+1 + cin*(kh_1+1) + kh.
    task automatic model_gen(input bit bank, input int kh_1, input int cin_1,
                             input int cols_1, input int blocks_1, input int cfg_1);
        beat_t b;
        gen_q.delete();
        for (int blk = 0; blk <= blocks_1; blk++) begin
            for (int c = 0; c <= cfg_1; c++) begin
                b = '0;
                b.bank = bank; b.is_cfg = 1'b1; b.addr = 10'(c);
                b.top = (blk == 0); b.bot = (blk == blocks_1);
                gen_q.push_back(b);
            end
            for (int col = 0; col <= cols_1; col++)
                for (int ci = 0; ci <= cin_1; ci++)
                    for (int k = 0; k <= kh_1; k++) begin
                        b = '0;
                        b.bank = bank;
                        b.addr = 10'(cfg_1 + 1 + ci * (kh_1 + 1) + k);
                        b.cin_last = (ci == cin_1);
                        b.top = (blk == 0); b.bot = (blk == blocks_1);
                        b.last = (blk == blocks_1) && (col == cols_1) && (ci == cin_1) && (k == kh_1);
                        gen_q.push_back(b);
                    end
        end
    endtask

    // Entered at posedge+1; the acceptance decision is taken from the model before the edge.
    task automatic do_wdone(input int kh, input int cin, input int cols, input int blks, input int cfg);
        bit acc;
        acc        = !m_full(m_wb);
        w_kh_1     = 4'(kh);
        w_cin_1    = 10'(cin);
        w_cols_1   = 10'(cols);
        w_blocks_1 = 8'(blks);
        w_cfg_1    = 4'(cfg);
        w_done     = 1'b1;
        @(posedge aclk); #1;
        w_done = 1'b0;
        if (acc) begin
            model_gen(m_wb, kh, cin, cols, blks, cfg);
            foreach (gen_q[i]) begin
                exp_arr[wr_ptr % 1024] = gen_q[i];
                wr_ptr++;
            end
            fill_cnt[m_wb]++;
            m_wb = !m_wb;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic drain(input string name, input bit rnd);
        int n = 0;
        while (!(rd_ptr == wr_ptr && !r_valid) && n < 3000) begin
            @(posedge aclk); #1;
            if (rnd) r_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check({name, "_drain_done"}, 32'(rd_ptr == wr_ptr && !r_valid), 1);
        r_ready = 1'b1;
    endtask

    always @(negedge aclk) begin
        logic [16:0] cur_vec;
        beat_t       got;
        cur_vec = {r_valid, r_bank, r_is_config, r_cin_last, r_top_blk, r_bot_blk, r_last, r_addr};
        got     = {r_bank, r_is_config, r_cin_last, r_top_blk, r_bot_blk, r_last, r_addr};
        if (!aresetn) begin
            rd_ptr     = wr_ptr;
            rel_cnt[0] = fill_cnt[0];
            rel_cnt[1] = fill_cnt[1];
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            have_rel   = 1'b0;
        end else begin
            neg_cyc++;
            check("w_ready", 32'(w_ready), 32'(!m_full(m_wb)));
            check("w_bank", 32'(w_bank), 32'(m_wb));
            check("err_ovf", 32'(err_ovf), 32'(m_err));
            if (prev_stall) check("stall_hold", 32'(cur_vec), 32'(prev_vec));
            if (r_valid && !prev_valid) begin
                rise_bank = r_bank;
                if (have_rel) begin
                    m_gap = neg_cyc - last_hs_cyc;
                    check("bank_gap_min2", 32'(m_gap >= 2), 1);
                end
            end
            if (r_valid) check("valid_has_work", 32'(rd_ptr != wr_ptr), 1);
            if (r_valid && r_ready && rd_ptr != wr_ptr) begin
                check($sformatf("beat[%0d]", rd_ptr), 32'(got), 32'(exp_arr[rd_ptr % 1024]));
                if (exp_arr[rd_ptr % 1024].last) begin
                    rel_cnt[exp_arr[rd_ptr % 1024].bank]++;
                    last_hs_cyc = neg_cyc;
                    have_rel    = 1'b1;
                end
                rd_ptr++;
                hs_cnt++;
            end
            prev_stall = r_valid && !r_ready;
            prev_vec   = cur_vec;
            prev_valid = r_valid;
        end
    end

    initial begin
        int start;
        int n;
        w_done = 1'b0; w_kh_1 = '0; w_cin_1 = '0; w_cols_1 = '0; w_blocks_1 = '0; w_cfg_1 = '0;
        r_ready = 1'b0;
        repeat (3) @(posedge aclk); #1;
        check("rst_r_valid", 32'(r_valid), 0);
        check("rst_w_ready", 32'(w_ready), 1);
        check("rst_w_bank", 32'(w_bank), 0);
        check("rst_r_addr", 32'(r_addr), 0);
        check("rst_r_flags", 32'({r_bank, r_is_config, r_cin_last, r_top_blk, r_bot_blk, r_last}), 0);
        check("rst_err_ovf", 32'(err_ovf), 0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Basic replay: 2 config + 2 cols x 9 weight beats
        r_ready = 1'b1;
        start = hs_cnt;
        do_wdone(2, 2, 1, 0, 1);
        check("basic_model_len", 32'(gen_q.size()), 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("basic_model_addr[%0d]", i), 32'(gen_q[i].addr), 32'(lit_b_addr[i]));
            check($sformatf("basic_model_cfg[%0d]", i), 32'(gen_q[i].is_cfg), 32'(i < 2));
            check($sformatf("basic_model_cinl[%0d]", i), 32'(gen_q[i].cin_last),
                  32'(i >= 2 && lit_b_addr[i] >= 8));
            check($sformatf("basic_model_last[%0d]", i), 32'(gen_q[i].last), 32'(i == 19));
        end
        drain("basic", 1'b0);
        check("basic_beats", 32'(hs_cnt - start), 20);
        check("basic_w_ready_back", 32'(w_ready), 1);

        // Blocks: config replays once per block
        start = hs_cnt;
        do_wdone(0, 0, 0, 2, 0);
        check("blk_model_len", 32'(gen_q.size()), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("blk_model_addr[%0d]", i), 32'(gen_q[i].addr), 32'(lit_k_addr[i]));
            check($sformatf("blk_model_cfg[%0d]", i), 32'(gen_q[i].is_cfg), 32'(lit_k_cfg[i]));
            check($sformatf("blk_model_top[%0d]", i), 32'(gen_q[i].top), 32'(lit_k_top[i]));
            check($sformatf("blk_model_bot[%0d]", i), 32'(gen_q[i].bot), 32'(lit_k_bot[i]));
        end
        drain("blocks", 1'b0);
        check("blocks_beats", 32'(hs_cnt - start), 6);

        // Ping-pong: back-to-back fills of bank 0 and bank 1
        start = hs_cnt;
        do_wdone(2, 2, 1, 0, 1);
        do_wdone(1, 0, 0, 1, 2);
        check("pp_w_ready_low", 32'(w_ready), 0);
        drain("pingpong", 1'b0);
        check("pp_beats", 32'(hs_cnt - start), 20 + 10);
        check("pp_gap", 32'(m_gap), 2);
        check("pp_second_bank", 32'(rise_bank), 1);

        // Random back-pressure on the basic replay
        start = hs_cnt;
        do_wdone(2, 2, 1, 0, 1);
        drain("random", 1'b1);
        check("random_beats", 32'(hs_cnt - start), 20);

        // Overflow: third fill with both banks full is dropped
        start = hs_cnt;
        r_ready = 1'b0;
        do_wdone(2, 2, 1, 0, 1);
        do_wdone(0, 0, 0, 2, 0);
        do_wdone(1, 1, 1, 1, 3);
        check("ovf_err", 32'(err_ovf), 1);
        check("ovf_w_ready", 32'(w_ready), 0);
        repeat (3) @(posedge aclk); #1;
        r_ready = 1'b1;
        drain("overflow", 1'b0);
        check("ovf_beats", 32'(hs_cnt - start), 26);

        // Reset in the middle of the weight beats
        start = hs_cnt;
        do_wdone(2, 2, 1, 0, 1);
        n = 0;
        while (hs_cnt - start < 6 && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        check("rst_mid_reached", 32'(hs_cnt - start >= 6), 1);
        check("rst_mid_in_weights", 32'({r_valid, r_is_config}), 32'(2'b10));
        aresetn = 1'b0;
        #1;
        check("rst_mid_r_valid", 32'(r_valid), 0);
        check("rst_mid_w_ready", 32'(w_ready), 1);
        check("rst_mid_err", 32'(err_ovf), 0);
        m_wb  = 1'b0;
        m_err = 1'b0;
        repeat (2) @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        do_wdone(0, 0, 0, 2, 0);
        n = 0;
        while (!r_valid && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        check("post_rst_valid", 32'(r_valid), 1);
        check("post_rst_addr", 32'(r_addr), 0);
        check("post_rst_bank", 32'(r_bank), 0);
        check("post_rst_cfg", 32'(r_is_config), 1);
        drain("post_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
